// File: rtl/tick_gen_if.sv
// -----------------------------------------------------------------------------
// tick_gen_if
//
// Divisor-load handshake into tick_gen. A transfer fires on a rising clk edge
// where div_valid and div_ready are both high.
//
// Signals:
//   div_valid  master -> slave  a new divisor is offered
//   div_data   master -> slave  offered divisor, CNT_W bits (0 is stored as 1)
//   div_ready  slave -> master  tick_gen can accept a divisor
//
// Modports:
//   master  the side that offers divisors (controller or testbench)
//   slave   tick_gen
// -----------------------------------------------------------------------------
interface tick_gen_if #(
  parameter int unsigned CNT_W = 26
);

  logic             div_valid;
  logic [CNT_W-1:0] div_data;
  logic             div_ready;

  modport master (
    output div_valid,
    output div_data,
    input  div_ready
  );

  modport slave (
    input  div_valid,
    input  div_data,
    output div_ready
  );

endinterface : tick_gen_if

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Programmable prescaler. Divides clk by a runtime-loadable divisor and emits
// a registered one-cycle tick strobe once per period. The downstream phase
// controller expects one tick per second. Supports pause (en low holds the
// phase) and synchronous clear. A divisor offered while running is held
// pending and applied only at a period boundary, so a running period is never
// truncated or stretched. A free-running 16-bit count of issued ticks is kept
// for debug/status.
//
// Parameters:
//   CNT_W        width of the divisor and the period counter (26 covers 50 MHz)
//   DEFAULT_DIV  divisor after reset, in clk cycles per tick
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   count enable; low pauses and holds the count
//   clr         in   synchronous clear; count to 0, no tick that cycle
//   div_if      slave modport of tick_gen_if (div_valid / div_data / div_ready)
//   tick        out  one-cycle registered strobe
//   tick_total  out  ticks issued, wraps modulo 2^16
//
// Build option:
//   TICK_GEN_FAST_SIM_EN  when defined, the reset divisor is 10 instead of
//                         DEFAULT_DIV so system simulations run quickly.
//                         Divisor loads behave identically in both builds.
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  tick_gen_if.slave        div_if,
  output logic             tick,
  output logic [15:0]      tick_total
);

  // ---------------------------------------------------------------------------
  // Reset divisor, clamped so a zero parameter still yields a legal divisor.
  // ---------------------------------------------------------------------------
`ifdef TICK_GEN_FAST_SIM_EN
  localparam logic [CNT_W-1:0] RST_DIV_RAW = CNT_W'(10);
`else
  localparam logic [CNT_W-1:0] RST_DIV_RAW = CNT_W'(DEFAULT_DIV);
`endif
  localparam logic [CNT_W-1:0] RST_DIV =
    (RST_DIV_RAW == '0) ? CNT_W'(1) : RST_DIV_RAW;

  // IDLE     : paused; a divisor load applies immediately and restarts the count
  // RUN      : counting; a divisor load is parked in pend_div
  // RUN_PEND : counting with a parked divisor; handshake closed until applied
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } state_t;

  state_t           state, state_nxt;

  logic [CNT_W-1:0] cnt,        cnt_nxt;
  logic [CNT_W-1:0] active_div, active_div_nxt;
  logic [CNT_W-1:0] pend_div,   pend_div_nxt;
  logic             tick_nxt;
  logic [15:0]      tick_total_nxt;

  logic             fire;
  logic [CNT_W-1:0] div_in;
  logic             at_last;
  logic             wrap;
  logic             load_direct;
  logic             store_pend;
  logic             apply_pend;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign fire    = div_if.div_valid && div_if.div_ready;
  assign div_in  = (div_if.div_data == '0) ? CNT_W'(1) : div_if.div_data;
  assign at_last = (cnt == active_div - CNT_W'(1));
  // Period boundary: this edge issues a tick.
  assign wrap    = en && !clr && at_last;

  // A load while paused (IDLE, or RUN with en just dropped) takes effect at
  // once: there is no running period to protect.
  assign load_direct = fire && ((state == IDLE) || ((state == RUN) && !en));
  assign store_pend  = fire && (state == RUN) && en;
  // The parked divisor is applied at the wrap, on a pause, or on a clear.
  assign apply_pend  = (state == RUN_PEND) && (!en || clr || wrap);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every register uses non-blocking assignment so all flops sample
  // their inputs from the same pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the output is assigned a default before any branch so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en)       state_nxt = IDLE;
        else if (fire) state_nxt = RUN_PEND;
      end
      RUN_PEND: begin
        if (!en)              state_nxt = IDLE;
        else if (clr || wrap) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Ready is purely a function of state: closed only while a divisor is parked.
  always_comb begin
    div_if.div_ready = 1'b1;
    unique case (state)
      IDLE:     div_if.div_ready = 1'b1;
      RUN:      div_if.div_ready = 1'b1;
      RUN_PEND: div_if.div_ready = 1'b0;
      default:  div_if.div_ready = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: next values for counter, divisors and tick outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_nxt        = cnt;
    tick_nxt       = 1'b0;
    tick_total_nxt = tick_total;
    active_div_nxt = active_div;
    pend_div_nxt   = pend_div;

    // Count rule. A direct load restarts the period exactly like a clear.
    if (clr || load_direct) begin
      cnt_nxt = '0;
    end else if (en && at_last) begin
      cnt_nxt        = '0;
      tick_nxt       = 1'b1;
      tick_total_nxt = tick_total + 16'd1;
    end else if (en) begin
      cnt_nxt = cnt + CNT_W'(1);
    end

    // Divisor update. Every path that changes active_div also leaves cnt at 0,
    // which keeps cnt below the new divisor.
    if (load_direct) begin
      active_div_nxt = div_in;
    end else if (store_pend) begin
      pend_div_nxt = div_in;
    end else if (apply_pend) begin
      active_div_nxt = pend_div;
      if (!en) cnt_nxt = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: pend_div is reset along with everything else; an offered divisor
  // must not survive a reset, and the flop count is small enough that there
  // is no reason to leave any state undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      active_div <= RST_DIV;
      pend_div   <= RST_DIV;
      tick       <= 1'b0;
      tick_total <= '0;
    end else begin
      cnt        <= cnt_nxt;
      active_div <= active_div_nxt;
      pend_div   <= pend_div_nxt;
      tick       <= tick_nxt;
      tick_total <= tick_total_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_cnt_in_range : assert property (
    @(posedge clk) disable iff (!rst_n) cnt < active_div
  );
  a_div_nonzero : assert property (
    @(posedge clk) disable iff (!rst_n) active_div != '0
  );
`endif

endmodule : tick_gen

// File: doc/tick_gen.md
# tick_gen

Programmable prescaler that produces the single-cycle `tick` strobe consumed by the traffic-light phase controller, which expects one tick per second. Divides `clk` by a runtime-loadable divisor and supports pause and synchronous clear. Divisor updates arrive over a valid/ready handshake and take effect only at a period boundary, so a tick period is never truncated or stretched mid-count. Also keeps a free-running count of ticks issued, for debug and status.

## Interface
- `CNT_W`, default 26: width of the divisor and of the period counter; 26 bits covers 50 MHz.
- `DEFAULT_DIV`, default 50_000_000: divisor value after reset, in clk cycles per tick.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  count enable; low pauses the counter and holds its value.
- `clr`  in  1  synchronous clear; sets the counter to 0 and suppresses `tick` that cycle.
- `div_valid`  in  1  new divisor offered.
- `div_data`  in  CNT_W  offered divisor.
- `div_ready`  out  1  block can accept a divisor.
- `tick`  out  1  one-cycle strobe, registered.
- `tick_total`  out  16  count of ticks issued; wraps modulo 2^16.

## Operation
- Internal registers:
  - `cnt`, CNT_W bits
  - `active_div`
  - `pend_div`
  - state: IDLE / RUN / RUN_PEND
- Divisor clamp: an accepted `div_data` of 0 is stored as 1. A divisor of 1 produces a tick on every enabled cycle.
- Count rule, per edge, in priority order:
  1. If `clr`: `cnt` <= 0 and `tick` <= 0.
  2. Else if `en` and `cnt == active_div-1`: `cnt` <= 0, `tick` <= 1, `tick_total` += 1.
  3. Else if `en`: `cnt` += 1 and `tick` <= 0.
  4. Else: `cnt` holds and `tick` <= 0.
- A handshake fires when `div_valid && div_ready` is sampled at an edge.
- State transitions:
  - IDLE (`en`=0): a fire loads `active_div` directly and sets `cnt` <= 0. `div_ready`=1. Goes to RUN when `en`=1.
  - RUN: `div_ready`=1. A fire stores `pend_div` and goes to RUN_PEND. Goes to IDLE when `en`=0.
  - RUN_PEND: `div_ready`=0. On the wrap edge (rule 2), `active_div` <= `pend_div` and state goes to RUN. If `en` falls, `active_div` <= `pend_div`, `cnt` <= 0, and state goes to IDLE. `clr` also applies `pend_div` immediately and goes to RUN.
- If a fire coincides with a wrap edge while in RUN, the new value is held pending. It applies at the next wrap, so the period that just started uses the old divisor.
- `cnt` must never exceed `active_div-1`.

## Timing
- Reset values:
  - `tick`=0, `tick_total`=0, `div_ready`=1
  - `cnt`=0, `active_div`=DEFAULT_DIV (clamped), state IDLE
- With divisor N and `en` held high from edge 1, `tick` is high during the cycle after edges N, 2N, 3N, …. The period is exactly N cycles and each pulse is exactly 1 cycle wide.
- A pause preserves phase: a gap of k cycles with `en`=0 delays the next tick by exactly k cycles.
- `div_ready` falls the cycle after a fire in RUN. It rises again the cycle after the divisor is applied.
- `tick_total` updates on the same edge that sets `tick`.
- Asserting `rst_n` mid-period clears every output immediately, including a `tick` that is currently high. Any pending divisor is discarded.

## Configuration
- `TICK_GEN_FAST_SIM_EN`
  - Defined: the reset value of `active_div` is 10 instead of DEFAULT_DIV, so simulations of the downstream controller run in microseconds. Divisor loads still work normally.
  - Undefined: the reset value is DEFAULT_DIV.
- No other behaviour differs between the two builds.

## Test plan
- Period check: reset, load div=4 while in IDLE, hold `en`=1. Required: `tick` high on cycles 4, 8, 12; `tick_total`=3 after cycle 12.
- Pause: div=5, drop `en` for 3 cycles at `cnt`=2. Required: the next tick arrives 3 cycles late; no tick occurs while paused.
- Mid-run reload: div=6 running; offer 3 at `cnt`=2. Required: `div_ready` goes low; the current period completes at 6 cycles; subsequent periods are 3 cycles; `div_ready` returns high.
- Edge cases:
  - Load 0: required behaviour is a tick every enabled cycle.
  - Fire coincident with a wrap edge: required behaviour is that the old divisor is used for one more full period.
- `clr` while `div_ready`=0: required behaviour is that `cnt`=0, there is no tick that cycle, the pending divisor is applied immediately, and `div_ready`=1 next cycle.
- Async reset: assert `rst_n`=0 while `tick`=1, mid-cycle. Required: all outputs return to their reset values before the next edge. With `TICK_GEN_FAST_SIM_EN` defined, the first tick follows 10 cycles after release.
